// File: rtl/uart_rx_if.sv
// Host-side holding-register handshake of the UART receiver.
// The receiver drives the master modport; host logic takes the slave modport.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ack;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output parity_err,
    output overrun,
    input  rx_ack
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  parity_err,
    input  overrun,
    output rx_ack
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: recovers LSB-first frames with optional parity
// and presents each byte in a holding register with a valid/ack handshake.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OSR        = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_en,
  input  logic       rx,
  uart_rx_if.master  host,
  output logic       busy
);

  localparam int CNT_W = $clog2(OSR);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OSR / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 rx_p0, rx_p1;
  logic                 rx_s;
  logic [DATA_BITS-1:0] shreg;
  logic                 pend_perr;
  logic                 shift_en, par_smp, done, clr_pend;
  logic                 load_ok;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, ferr_q, perr_q, ovr_q;

  // Parity check over data plus received parity bit.
  function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
    return ((^d) ^ p) != (PARITY_ODD != 0);
  endfunction

  // Stage p0/p1: two-flop synchronizer; the line idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end

  assign rx_s = rx_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_en = 1'b0;
    par_smp  = 1'b0;
    done     = 1'b0;
    clr_pend = 1'b0;
    if (rx_en) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_d  = S_START;
            cnt_d    = '0;
            clr_pend = 1'b1;
          end
        end
        S_START: begin
          // A start bit that is high again at its midpoint was a glitch.
          if (cnt_q == CNT_MID) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d    = '0;
            idx_d    = idx_q + 1'b1;
            shift_en = 1'b1;
            if (idx_q == IDX_LAST)
              state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            par_smp = 1'b1;
            state_d = S_STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          // A low stop bit parks in BREAK so a held-low line yields one frame.
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            done    = 1'b1;
            state_d = rx_s ? S_IDLE : S_BREAK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_BREAK: begin
          if (rx_s)
            state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // An ack in the completion cycle frees the holding register for the new frame.
  assign load_ok = !valid_q || host.rx_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg     <= '0;
      pend_perr <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (shift_en)
        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      if (clr_pend)
        pend_perr <= 1'b0;
      else if (par_smp)
        pend_perr <= parity_bad(shreg, rx_s);
      if (done && load_ok) begin
        data_q  <= shreg;
        ferr_q  <= !rx_s;
        perr_q  <= pend_perr;
        valid_q <= 1'b1;
      end else begin
        if (done)
          ovr_q <= 1'b1;
        if (host.rx_ack && valid_q)
          valid_q <= 1'b0;
      end
    end
  end

  assign host.rx_data    = data_q;
  assign host.rx_valid   = valid_q;
  assign host.frame_err  = ferr_q;
  assign host.parity_err = perr_q;
  assign host.overrun    = ovr_q;
  assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames at OSR=16 with a tick every clk; a
// scoreboard queue per receiver is checked by a monitor on each new rx_valid.
module tb_uart_rx;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx_en = 1'b1;
  logic rx0 = 1'b1;
  logic rx1 = 1'b1;
  logic busy0, busy1;
  logic ack0_a = 1'b0, ack0_m = 1'b0, ack1_a = 1'b0;
  bit   auto0 = 1'b0, auto1 = 1'b1;

  uart_rx_if #(.DATA_BITS(8)) if0 ();
  uart_rx_if #(.DATA_BITS(8)) if1 ();

  assign if0.rx_ack = ack0_a | ack0_m;
  assign if1.rx_ack = ack1_a;

  uart_rx #(.DATA_BITS(8), .OSR(16), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
    .clk(clk), .reset(reset), .rx_en(rx_en), .rx(rx0), .host(if0.master), .busy(busy0)
  );

  uart_rx #(.DATA_BITS(8), .OSR(16), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .reset(reset), .rx_en(rx_en), .rx(rx1), .host(if1.master), .busy(busy1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  bit   seen0 = 1'b0, seen1 = 1'b0;
  int   frames0 = 0, frames1 = 0, rise0 = 0, ov_cnt = 0, ov_cyc = 0;

  // Monitor: every new rx_valid pops the oldest expected frame.
  always @(negedge clk) begin
    if (if0.overrun === 1'b1) begin
      ov_cnt++;
      ov_cyc = cyc;
    end
    if (if0.rx_valid !== 1'b1) begin
      seen0 = 1'b0;
    end else if (!seen0) begin
      seen0 = 1'b1;
      frames0++;
      rise0 = cyc;
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut0_unexpected_frame: got data 0x%0h, expected no frame", if0.rx_data);
      end else begin
        e0 = q0.pop_front();
        chk("dut0_rx_data", 32'(if0.rx_data), 32'(e0.d));
        chk("dut0_frame_err", 32'(if0.frame_err), 32'(e0.fe));
        chk("dut0_parity_err", 32'(if0.parity_err), 32'(e0.pe));
      end
    end
    if (if1.rx_valid !== 1'b1) begin
      seen1 = 1'b0;
    end else if (!seen1) begin
      seen1 = 1'b1;
      frames1++;
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1_unexpected_frame: got data 0x%0h, expected no frame", if1.rx_data);
      end else begin
        e1 = q1.pop_front();
        chk("dut1_rx_data", 32'(if1.rx_data), 32'(e1.d));
        chk("dut1_frame_err", 32'(if1.frame_err), 32'(e1.fe));
        chk("dut1_parity_err", 32'(if1.parity_err), 32'(e1.pe));
      end
    end
  end

  // Host emulation: acknowledge one clk after a frame is seen.
  always @(negedge clk) begin
    if (ack0_a) ack0_a = 1'b0;
    else if (auto0 && if0.rx_valid === 1'b1) ack0_a = 1'b1;
    if (ack1_a) ack1_a = 1'b0;
    else if (auto1 && if1.rx_valid === 1'b1) ack1_a = 1'b1;
  end

  task automatic drive_bit(input int sel, input logic v);
    if (sel == 0) rx0 = v;
    else rx1 = v;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input bit pen,
                            input bit pbit, input bit sbit);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (pen) drive_bit(sel, pbit);
    drive_bit(sel, sbit);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  int c0, base;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_dut0", 32'({if0.rx_data, if0.rx_valid, if0.frame_err, if0.parity_err,
                           if0.overrun, busy0}), 32'd0);
    chk("reset_dut1", 32'({if1.rx_data, if1.rx_valid, if1.frame_err, if1.parity_err,
                           if1.overrun, busy1}), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Clean 0x55, valid held until a manual ack.
    q0.push_back('{d: 8'h55, fe: 1'b0, pe: 1'b0});
    c0 = cyc;
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
    chk("latency_0x55", 32'(rise0 - c0), 32'd155);
    repeat (20) @(negedge clk);
    chk("valid_held", 32'(if0.rx_valid), 32'd1);
    ack0_m = 1'b1;
    @(negedge clk);
    ack0_m = 1'b0;
    chk("ack_clears_valid", 32'(if0.rx_valid), 32'd0);
    chk("data_held_after_ack", 32'(if0.rx_data), 32'h55);
    auto0 = 1'b1;
    repeat (8) @(negedge clk);

    // Start-bit glitch: 4 ticks low.
    base = frames0;
    rx0 = 1'b0;
    repeat (4) @(negedge clk);
    chk("glitch_busy_set", 32'(busy0), 32'd1);
    rx0 = 1'b1;
    for (int i = 0; i < 16 && busy0 !== 1'b0; i++) @(negedge clk);
    chk("glitch_busy_clears", 32'(busy0), 32'd0);
    repeat (32) @(negedge clk);
    chk("glitch_no_frame", 32'(frames0 - base), 32'd0);

    // Framing error followed by a long break, then a clean frame.
    base = frames0;
    q0.push_back('{d: 8'hA3, fe: 1'b1, pe: 1'b0});
    send_frame(0, 8'hA3, 1'b0, 1'b0, 1'b0);
    repeat (40 * 16) @(negedge clk);
    chk("break_one_frame", 32'(frames0 - base), 32'd1);
    rx0 = 1'b1;
    repeat (32) @(negedge clk);
    q0.push_back('{d: 8'h3C, fe: 1'b0, pe: 1'b0});
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    chk("after_break_frames", 32'(frames0 - base), 32'd2);
    auto0 = 1'b0;

    // Overrun: 0x11 then 0x22 with no ack.
    base = ov_cnt;
    q0.push_back('{d: 8'h11, fe: 1'b0, pe: 1'b0});
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    c0 = cyc;
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
    chk("overrun_pulses", 32'(ov_cnt - base), 32'd1);
    chk("overrun_timing", 32'(ov_cyc - c0), 32'd155);
    chk("overrun_data_kept", 32'(if0.rx_data), 32'h11);
    chk("overrun_valid_kept", 32'(if0.rx_valid), 32'd1);

    // Ack coinciding with frame completion: new frame loads, no overrun.
    base = ov_cnt;
    c0 = cyc;
    fork
      send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
      begin
        while (cyc < c0 + 154) @(negedge clk);
        ack0_m = 1'b1;
        @(negedge clk);
        ack0_m = 1'b0;
        chk("same_cycle_data", 32'(if0.rx_data), 32'h5A);
        chk("same_cycle_valid", 32'(if0.rx_valid), 32'd1);
      end
    join
    chk("same_cycle_no_overrun", 32'(ov_cnt - base), 32'd0);

    // Reset during data bit 4 of 0xF0.
    c0 = cyc;
    fork
      send_frame(0, 8'hF0, 1'b0, 1'b0, 1'b1);
      begin
        repeat (88) @(negedge clk);
        chk("pre_reset_busy_valid", 32'({busy0, if0.rx_valid}), 32'b11);
        #1 reset = 1'b1;
        #1;
        chk("reset_midframe_outputs", 32'({if0.rx_data, if0.rx_valid, if0.frame_err,
                                           if0.parity_err, if0.overrun, busy0}), 32'd0);
      end
    join
    @(negedge clk);
    reset = 1'b0;
    auto0 = 1'b1;
    repeat (16) @(negedge clk);
    q0.push_back('{d: 8'h81, fe: 1'b0, pe: 1'b0});
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);

    // Even parity on the parity-enabled receiver.
    q1.push_back('{d: 8'h07, fe: 1'b0, pe: 1'b1});
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
    q1.push_back('{d: 8'h07, fe: 1'b0, pe: 1'b0});
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);

    repeat (64) @(negedge clk);
    chk("dut0_all_frames_seen", 32'(q0.size()), 32'd0);
    chk("dut1_all_frames_seen", 32'(q1.size()), 32'd0);
    chk("dut1_frame_count", 32'(frames1), 32'd2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial-to-parallel UART receiver. It is the receive-side consumer of the baud generator's Rx_en tick.
- Input `rx_en` is a one-clk-wide sample tick at OSR times the baud rate. For 9600 baud at 16x, the baud divider is configured for 16x ticks.
- Recovers 8N1 frames (optional parity), LSB first, and presents each byte in a holding register with a valid/ack handshake to the host logic.

Parameters:
- DATA_BITS, 8, data bits per frame (5-8).
- OSR, 16, `rx_en` ticks per bit period (even, >=8).
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity (used only when PARITY_EN=1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_en  in  1  oversample tick, one clk cycle wide
- rx  in  1  serial line, idle high, asynchronous to clk
- rx_ack  in  1  host consumed rx_data; clears rx_valid
- rx_data  out  DATA_BITS  received byte, held until next accepted frame
- rx_valid  out  1  rx_data holds an unconsumed frame
- frame_err  out  1  stop bit sampled 0 for the frame in rx_data
- parity_err  out  1  parity mismatch for the frame in rx_data
- overrun  out  1  one-clk pulse: frame completed while rx_valid=1
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (asynchronous, active-high):
  - rx_data=0; rx_valid, frame_err, parity_err, overrun, busy all 0.
  - Synchronizer flops = 1; FSM = IDLE; tick counter = 0; bit index = 0.
  - Reset mid-frame discards the partial frame.
- Input synchronizer: `rx` passes through a 2-flop synchronizer; all decisions use the synchronized `rx_s`.
- State and counter advance only on clk edges where rx_en=1. The exceptions are the rx_ack handling and the overrun pulse.
- IDLE:
  - On a tick with rx_s=0: go to START, cnt=0.
- START:
  - Each tick: cnt++.
  - When cnt reaches OSR/2-1 (mid start bit): if rx_s=0, go to DATA with cnt=0 and bit_idx=0; otherwise treat as a glitch and return to IDLE with no flags.
- DATA:
  - Each tick: cnt++.
  - At cnt=OSR-1: shift rx_s into the shift register MSB end, so the final byte is LSB-first. Then cnt=0 and bit_idx++.
  - After DATA_BITS samples: go to PARITY if PARITY_EN, else STOP.
- PARITY:
  - At cnt=OSR-1: sample the parity bit.
  - Mismatch (XOR of data and parity bit != PARITY_ODD) sets the pending parity error.
  - Then go to STOP, cnt=0.
- STOP:
  - At cnt=OSR-1: sample the stop bit, then complete the frame:
    - if rx_valid=0 (or rx_ack is asserted in the same cycle): load rx_data, frame_err=!rx_s, parity_err=pending, rx_valid=1;
    - else: leave rx_data and flags unchanged; overrun=1 for one clk.
  - Next state: IDLE if rx_s=1; BREAK if rx_s=0.
- BREAK:
  - Wait for a tick with rx_s=1, then go to IDLE.
  - A held-low line produces exactly one framing-error frame.
- Latency and handshake:
  - rx_valid rises on the clk edge of the stop-bit sample tick.
  - rx_ack with rx_valid=1 clears rx_valid on the next edge.
  - rx_ack with rx_valid=0 is ignored.
  - Frame completion and rx_ack in the same cycle: the new frame is loaded, rx_valid stays 1, no overrun.
- busy = (state != IDLE).
- All counters are sized ceil(log2(OSR)) and ceil(log2(DATA_BITS+1)). No wrap occurs beyond the explicit resets above.

Test Plan:
- Bench setup: OSR=16, rx_en=1 every clk, bit period 16 clk.
- Frame 0x55, 8N1 -> rx_valid=1 about 152 clk after the start edge (plus 2 sync cycles); rx_data=0x55; frame_err=0; rx_valid held until rx_ack, cleared next clk.
- rx low for 4 ticks, then high -> no rx_valid; busy returns to 0 within 8 ticks; state IDLE.
- Frame 0xA3 with stop bit 0, line then held low 40 bit periods, then high; then frame 0x3C -> first frame: rx_data=0xA3, frame_err=1, exactly one rx_valid. After rx_ack: 0x3C, frame_err=0.
- PARITY_EN=1, PARITY_ODD=0: send 0x07 with parity bit 0 -> parity_err=1. Send 0x07 with parity bit 1 -> parity_err=0.
- Frames 0x11 then 0x22 with no rx_ack -> rx_data stays 0x11; overrun pulses 1 clk at the second stop sample; rx_valid stays 1.
- Reset asserted during data bit 4 of 0xF0 -> all outputs 0 immediately; after release, frame 0x81 -> rx_data=0x81, no flags.
